dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words of storage.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, extra wait states per access (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  memory stage presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address, taken from ALUResultM.
REQ-009 SHALL have port req_wdata  input  32  store data, taken from WriteDataM.
REQ-010 SHALL have port req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-011 SHALL have port req_unsigned  input  1  1 = zero-extend loads, 0 = sign-extend loads.
REQ-012 SHALL have port rsp_valid  output  1  response available.
REQ-013 SHALL have port rsp_ready  input  1  memory stage consumes the response.
REQ-014 SHALL have port rsp_rdata  output  32  load data after extension; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1  access was misaligned, out of range or illegal size.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP: IDLE->WAIT on accept when WAIT_CYCLES>0; IDLE->RESP on accept when WAIT_CYCLES=0; WAIT->RESP when the counter reaches WAIT_CYCLES; RESP->IDLE when rsp_ready=1.
REQ-017 SHALL assert req_ready only in IDLE; accept = req_valid & req_ready; all req_* fields latched on accept.
REQ-018 SHALL assert rsp_valid only in RESP, holding rsp_rdata and rsp_err stable until rsp_ready=1.
REQ-019 SHALL give latency: accept edge at cycle N -> rsp_valid high at cycle N+1+WAIT_CYCLES.
REQ-020 SHALL decide errors as: half with addr[0]=1, word with addr[1:0]!=00, size=11, or addr[31:2]>=DEPTH_WORDS.
REQ-021 SHALL commit store byte lanes on the edge entering RESP: byte -> lane addr[1:0], half -> lanes addr[1]*2 +{0,1}; other lanes unchanged.
REQ-022 SHALL suppress the memory write and return rsp_rdata=0 on an erroring access.
REQ-023 SHALL, for loads, select the byte/half by addr[1:0] and sign- or zero-extend per req_unsigned; word loads return the word unchanged.
REQ-024 SHALL read the memory at the edge entering RESP, so a load issued after a store response sees the stored data.
REQ-025 SHALL ignore req_valid while not in IDLE; a request held through RESP is accepted in the first IDLE cycle.
REQ-026 SHALL allow back-to-back operation: rsp_ready=1 in RESP and req_valid=1 -> accept on the next cycle (one IDLE bubble).

Reset
REQ-027 SHALL, while rst=1, force state IDLE, wait counter 0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-028 SHALL set req_ready=1 in the first cycle after rst deasserts.
REQ-029 SHALL, on rst during WAIT or RESP, abandon the pending access: no write if not yet committed and no response.
REQ-030 SHALL not clear memory contents on reset.

Structure
REQ-031 SHALL take the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum from shared package dmem_pkg.
REQ-032 SHALL place load extract/extend and store lane-merge logic in one combinational sub-module, dmem_lane_align.
REQ-033 SHALL keep the storage an inferred word array of DEPTH_WORDS entries, indexed by addr[31:2].

Verification
REQ-034 SHALL verify reset: rst=1 for 2 cycles -> req_ready=0 and rsp_valid=0; the cycle after release -> req_ready=1.
REQ-035 SHALL verify a word store then load: store addr 0x8, data 0x00001010 -> rsp_err=0; load addr 0x8 -> rsp_rdata=0x00001010, rsp_valid exactly 3 cycles after accept with WAIT_CYCLES=2.
REQ-036 SHALL verify byte extension: store word 0x80FF7F01 at 0x10; load byte signed at 0x12 -> 0xFFFFFFFF; load byte unsigned at 0x13 -> 0x00000080; load half signed at 0x10 -> 0x00007F01.
REQ-037 SHALL verify misalignment: word store at 0x3 with data 0x00001010 -> rsp_err=1 and rsp_rdata=0; a following word load at 0x0 returns the prior contents unchanged.
REQ-038 SHALL verify backpressure: hold rsp_ready=0 for 4 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable and req_ready=0; then rsp_ready=1 -> IDLE next cycle.
REQ-039 SHALL verify reset mid-operation: assert rst during WAIT of a store to 0x20 with data 0xDEADBEEF -> no response; a later load of 0x20 returns the old value.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access sizes, FSM states and
// the latched request payload.
package dmem_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned CNTW = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        size_e           size;
        logic            uns;
    } req_t;

    // Alignment / encoding error for a size at a given byte offset.
    function automatic logic misaligned(input size_e size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: load extract/extend and store lane merge
// against the currently stored word.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  size_e           size,
    input  logic [1:0]      off,
    input  logic            uns,
    input  logic [XLEN-1:0] rword,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_c,
    output logic [XLEN-1:0] merge_c
);

    logic [7:0]      sel_byte;
    logic [15:0]     sel_half;
    logic [3:0]      be;
    logic [XLEN-1:0] wrep;

    // Load path: pick the addressed byte/half and extend it.
    always_comb begin
        sel_byte = rword[{off, 3'b000} +: 8];
        sel_half = off[1] ? rword[31:16] : rword[15:0];
        load_c   = '0;
        case (size)
            SZ_BYTE: load_c = uns ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            SZ_HALF: load_c = uns ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
            SZ_WORD: load_c = rword;
            default: load_c = '0;
        endcase
    end

    // Store path: replicate the store data across lanes, then enable only the
    // lanes the access covers.
    always_comb begin
        be   = 4'b0000;
        wrep = wdata;
        case (size)
            SZ_BYTE: begin
                be   = 4'b0001 << off;
                wrep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be   = off[1] ? 4'b1100 : 4'b0011;
                wrep = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                be   = 4'b1111;
                wrep = wdata;
            end
            default: begin
                be   = 4'b0000;
                wrep = wdata;
            end
        endcase
        merge_c = rword;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merge_c[8*i +: 8] = wrep[8*i +: 8];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts a fixed
// number of wait states, and returns an extended load value or an error.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int unsigned IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    state_e          state;
    logic [CNTW-1:0] cnt;
    req_t            lat;
    req_t            cur;
    logic            accept_c;
    logic            enter_resp_c;
    logic            err_c;
    logic            commit_c;
    logic [IDXW-1:0] idx;
    logic [XLEN-1:0] rword;
    logic [XLEN-1:0] load_c;
    logic [XLEN-1:0] merge_c;

    assign accept_c = req_valid & req_ready;

    // With no wait states the access completes on the accept edge, so the
    // live request fields are used until the latched copy is valid.
    always_comb begin
        if (state == ST_IDLE) begin
            cur.we    = req_we;
            cur.addr  = req_addr;
            cur.wdata = req_wdata;
            cur.size  = size_e'(req_size);
            cur.uns   = req_unsigned;
        end else begin
            cur = lat;
        end
    end

    always_comb begin
        idx          = cur.addr[IDXW+1:2];
        err_c        = misaligned(cur.size, cur.addr[1:0])
                       || (cur.addr[XLEN-1:2] >= (XLEN-2)'(DEPTH_WORDS));
        rword        = (32'(idx) < DEPTH_WORDS) ? mem[idx] : '0;
        enter_resp_c = ((state == ST_IDLE) && accept_c && (WAIT_CYCLES == 0))
                       || ((state == ST_WAIT) && (cnt == CNTW'(WAIT_CYCLES)));
        commit_c     = enter_resp_c && !rst && cur.we && !err_c;
    end

    dmem_lane_align u_align (
        .size    (cur.size),
        .off     (cur.addr[1:0]),
        .uns     (cur.uns),
        .rword   (rword),
        .wdata   (cur.wdata),
        .load_c  (load_c),
        .merge_c (merge_c)
    );

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (commit_c) mem[idx] <= merge_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            lat       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        lat       <= cur;
                        req_ready <= 1'b0;
                        cnt       <= CNTW'(1);
                        state     <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (enter_resp_c) state <= ST_RESP;
                    else              cnt   <= cnt + CNTW'(1);
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        cnt       <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // Response is captured on the same edge that commits any store.
            if (enter_resp_c) begin
                rsp_valid <= 1'b1;
                rsp_err   <= err_c;
                rsp_rdata <= (err_c || cur.we) ? '0 : load_c;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder using a byte-addressed reference
// memory and a queue of expected responses.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned WAITC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       tag;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  mb [DEPTH*4];
    int unsigned nvec = 0;
    int unsigned nerr = 0;

    function automatic logic model_err(input logic [31:0] a, input logic [1:0] s);
        if (s == 2'b11) return 1'b1;
        if (s == 2'b01 && a[0]) return 1'b1;
        if (s == 2'b10 && a[1:0] != 2'b00) return 1'b1;
        return (a >> 2) >= 32'(DEPTH);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s, input logic u);
        int i;
        logic [7:0]  b;
        logic [15:0] h;
        i = int'(a);
        case (s)
            2'b00: begin
                b = mb[i];
                return u ? {24'h0, b} : {{24{b[7]}}, b};
            end
            2'b01: begin
                h = {mb[i+1], mb[i]};
                return u ? {16'h0, h} : {{16{h[15]}}, h};
            end
            default: return {mb[i+3], mb[i+2], mb[i+1], mb[i]};
        endcase
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] w, input logic [1:0] s);
        int i;
        i = int'(a);
        mb[i] = w[7:0];
        if (s != 2'b00) mb[i+1] = w[15:8];
        if (s == 2'b10) begin
            mb[i+2] = w[23:16];
            mb[i+3] = w[31:24];
        end
    endtask

    // Present a request, wait for acceptance, and record its expected response.
    task automatic send(input logic we, input logic [31:0] a, input logic [31:0] w,
                        input logic [1:0] s, input logic u, input bit track, input string tag);
        int   waited;
        exp_t e;
        waited       = 0;
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = a;
        req_wdata    = w;
        req_size     = s;
        req_unsigned = u;
        @(negedge clk);
        while (req_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        nvec++;
        if (waited >= 50) begin
            nerr++;
            $display("FAIL %s accept: req_ready=%b required 1 within 50 cycles", tag, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (track) begin
            e.err   = model_err(a, s);
            e.rdata = (e.err || we) ? 32'h0 : model_load(a, s, u);
            e.tag   = tag;
            sbq.push_back(e);
            if (we && !e.err) model_store(a, w, s);
        end
    endtask

    // Wait for a response, compare against the scoreboard, optionally consume it.
    task automatic recv(input bit consume, output int lat, output exp_t e);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (rsp_valid !== 1'b1 && lat < 60);
        e.rdata = 32'h0;
        e.err   = 1'b0;
        e.tag   = "empty";
        if (sbq.size() > 0) e = sbq.pop_front();
        nvec++;
        if (rsp_valid !== 1'b1) begin
            nerr++;
            $display("FAIL %s rsp_valid: got %b required 1 within 60 cycles", e.tag, rsp_valid);
            return;
        end
        nvec++;
        if (rsp_rdata !== e.rdata) begin
            nerr++;
            $display("FAIL %s rdata: got %h required %h", e.tag, rsp_rdata, e.rdata);
        end
        nvec++;
        if (rsp_err !== e.err) begin
            nerr++;
            $display("FAIL %s err: got %b required %b", e.tag, rsp_err, e.err);
        end
        if (consume) begin
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] w,
                        input logic [1:0] s, input logic u, input string tag);
        int   lat;
        exp_t e;
        send(we, a, w, s, u, 1'b1, tag);
        recv(1'b1, lat, e);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nvec++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            nerr++;
            $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b required 0 0 00000000 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        rst = 1'b0;
        @(negedge clk);
        nvec++;
        if (req_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_release: req_ready=%b required 1", req_ready);
        end
    endtask

    task automatic test_store_load();
        int   lat;
        exp_t e;
        xact(1'b1, 32'h8, 32'h0000_1010, 2'b10, 1'b0, "st_w_8");
        send(1'b0, 32'h8, 32'h0, 2'b10, 1'b0, 1'b1, "ld_w_8");
        recv(1'b1, lat, e);
        nvec++;
        if (lat !== 3) begin
            nerr++;
            $display("FAIL ld_latency: got %0d cycles required 3", lat);
        end
    endtask

    task automatic test_extension();
        xact(1'b1, 32'h10, 32'h80FF_7F01, 2'b10, 1'b0, "st_w_10");
        xact(1'b0, 32'h12, 32'h0, 2'b00, 1'b0, "ld_b_s_12");
        xact(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, "ld_b_u_13");
        xact(1'b0, 32'h10, 32'h0, 2'b01, 1'b0, "ld_h_s_10");
        xact(1'b0, 32'h12, 32'h0, 2'b01, 1'b0, "ld_h_s_12");
        xact(1'b0, 32'h12, 32'h0, 2'b01, 1'b1, "ld_h_u_12");
        xact(1'b0, 32'h11, 32'h0, 2'b00, 1'b0, "ld_b_s_11");
    endtask

    task automatic test_lanes();
        xact(1'b1, 32'h11, 32'h0000_00AA, 2'b00, 1'b0, "st_b_11");
        xact(1'b1, 32'h12, 32'hFFFF_1234, 2'b01, 1'b0, "st_h_12");
        xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, "ld_w_10");
        xact(1'b1, 32'h3FC, 32'h5A5A_A5A5, 2'b10, 1'b0, "st_w_last");
        xact(1'b0, 32'h3FE, 32'h0, 2'b01, 1'b1, "ld_h_last");
    endtask

    task automatic test_errors();
        xact(1'b1, 32'h0, 32'h1122_3344, 2'b10, 1'b0, "st_w_0");
        xact(1'b1, 32'h3, 32'h0000_1010, 2'b10, 1'b0, "st_w_3_misal");
        xact(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, "ld_w_0_after");
        xact(1'b0, 32'h11, 32'h0, 2'b01, 1'b0, "ld_h_11_misal");
        xact(1'b1, 32'h0, 32'hFFFF_FFFF, 2'b11, 1'b0, "st_size11");
        xact(1'b0, 32'h400, 32'h0, 2'b10, 1'b0, "ld_w_oob");
        xact(1'b1, 32'h1000, 32'hFFFF_FFFF, 2'b00, 1'b0, "st_b_oob");
        xact(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, "ld_w_0_final");
    endtask

    task automatic test_backpressure();
        int   lat;
        exp_t e;
        rsp_ready = 1'b0;
        send(1'b0, 32'h8, 32'h0, 2'b10, 1'b0, 1'b1, "ld_bp");
        recv(1'b0, lat, e);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            nvec++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err || req_ready !== 1'b0) begin
                nerr++;
                $display("FAIL bp_hold%0d: valid=%b rdata=%h err=%b ready=%b required 1 %h %b 0",
                         k, rsp_valid, rsp_rdata, rsp_err, req_ready, e.rdata, e.err);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        nvec++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            nerr++;
            $display("FAIL bp_release: valid=%b ready=%b required 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        exp_t e;
        exp_t eb;
        send(1'b1, 32'h30, 32'hA1B2_C3D4, 2'b10, 1'b0, 1'b1, "b2b_st");
        // Next request is held valid while the first is still in flight.
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_addr     = 32'h31;
        req_size     = 2'b00;
        req_unsigned = 1'b1;
        recv(1'b1, lat, e);
        @(negedge clk);
        nvec++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_bubble: ready=%b valid=%b required 1 0", req_ready, rsp_valid);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        eb.err    = model_err(32'h31, 2'b00);
        eb.rdata  = model_load(32'h31, 2'b00, 1'b1);
        eb.tag    = "b2b_ld";
        sbq.push_back(eb);
        recv(1'b1, lat, e);
        nvec++;
        if (lat !== 3) begin
            nerr++;
            $display("FAIL b2b_latency: got %0d cycles required 3", lat);
        end
    endtask

    task automatic test_reset_mid();
        xact(1'b1, 32'h20, 32'hCAFE_F00D, 2'b10, 1'b0, "st_w_20");
        send(1'b1, 32'h20, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0, "st_abandon");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            nvec++;
            if (rsp_valid !== 1'b0) begin
                nerr++;
                $display("FAIL mid_rst_norsp%0d: rsp_valid=%b required 0", k, rsp_valid);
            end
        end
        xact(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, "ld_w_20_old");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < int'(DEPTH * 4); i++) mb[i] = 8'h00;
        test_reset();
        test_store_load();
        test_extension();
        test_lanes();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        nvec++;
        if (sbq.size() != 0) begin
            nerr++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
